// File: rtl/nibbler_ram_arbiter.sv
// -----------------------------------------------------------------------------
// nibbler_ram_arbiter
//
// Shares the Nibbler's single 4096x4 data RAM between the CPU data port and a
// host/debug port. The host can load, inspect and patch RAM while the core is
// running. At most one access is granted per cycle. Read data coming back from
// the RAM (valid the cycle after the access) is steered to whichever port
// issued that read.
//
// Arbitration:
//   - a lone request always wins
//   - on contention the port that was not granted last wins (round-robin)
//   - a locked host that won last keeps the RAM while its burst count is
//     below MAX_BURST, so the CPU waits at most MAX_BURST cycles
//
// Ports:
//   clock, reset                   single clock, synchronous active-high reset
//   cpu_req/cpu_we/cpu_addr/
//   cpu_wdata                      CPU request (held until cpu_gnt)
//   cpu_gnt                        CPU access accepted this cycle (comb)
//   cpu_rvalid/cpu_rdata           CPU read return, one cycle after grant
//   host_req/host_we/host_lock/
//   host_addr/host_wdata           host request (held until host_gnt)
//   host_gnt                       host access accepted this cycle (comb)
//   host_rvalid/host_rdata         host read return, one cycle after grant
//   ram_cs/ram_we/ram_addr/
//   ram_wdata                      RAM macro drive, muxed from the winner
//   ram_rdata                      RAM read data, valid cycle after a read
//   conflict_cnt                   saturating count of contention cycles
// -----------------------------------------------------------------------------
module nibbler_ram_arbiter #(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 4,
    parameter int MAX_BURST = 8
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,

    input  logic              host_req,
    input  logic              host_we,
    input  logic              host_lock,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,

    output logic              ram_cs,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,

    output logic [7:0]        conflict_cnt
);

    // Width of the burst counter: must be able to hold MAX_BURST itself.
    localparam int BURST_W = $clog2(MAX_BURST + 1);
    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);

    // Owner encoding, shared by last_winner and rd_owner.
    localparam logic [0:0] WIN_CPU  = 1'b0;
    localparam logic [0:0] WIN_HOST = 1'b1;

    localparam logic [7:0] CONFLICT_MAX = 8'hFF;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [0:0]         last_winner_q, last_winner_d;
    logic [BURST_W-1:0] burst_cnt_q,   burst_cnt_d;
    logic               rd_pending_q,  rd_pending_d;
    logic [0:0]         rd_owner_q,    rd_owner_d;
    logic [DATA_W-1:0]  cpu_rdata_q,   cpu_rdata_d;
    logic [DATA_W-1:0]  host_rdata_q,  host_rdata_d;
    logic [7:0]         conflict_cnt_q, conflict_cnt_d;

    // -------------------------------------------------------------------------
    // Internal combinational signals
    // -------------------------------------------------------------------------
    logic cpu_win;
    logic host_win;
    logic both_req;
    logic host_keeps_bus;
    logic win_we;
    logic cpu_ret;
    logic host_ret;

    assign both_req = cpu_req & host_req;

    // A locked host holds the bus only if it won last time and has not yet
    // used up its burst allowance; otherwise plain round-robin applies.
    assign host_keeps_bus = host_lock
                          & (last_winner_q == WIN_HOST)
                          & (burst_cnt_q < BURST_MAX);

    // -------------------------------------------------------------------------
    // Grant decision. Grants are forced low during reset so nothing reaches
    // the RAM while the block is being initialised.
    // -------------------------------------------------------------------------
    always_comb begin
        cpu_win  = 1'b0;
        host_win = 1'b0;
        if (!reset) begin
            if (both_req) begin
                if (host_keeps_bus) begin
                    host_win = 1'b1;
                end else if (last_winner_q == WIN_HOST) begin
                    cpu_win = 1'b1;
                end else begin
                    host_win = 1'b1;
                end
            end else if (cpu_req) begin
                cpu_win = 1'b1;
            end else if (host_req) begin
                host_win = 1'b1;
            end
        end
    end

    assign cpu_gnt  = cpu_win;
    assign host_gnt = host_win;

    // -------------------------------------------------------------------------
    // RAM drive: everything comes from the winner, and the bus is parked at
    // zero when nobody is granted.
    // -------------------------------------------------------------------------
    always_comb begin
        ram_cs    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        win_we    = 1'b0;
        if (cpu_win) begin
            ram_cs    = 1'b1;
            ram_we    = cpu_we;
            ram_addr  = cpu_addr;
            ram_wdata = cpu_wdata;
            win_we    = cpu_we;
        end else if (host_win) begin
            ram_cs    = 1'b1;
            ram_we    = host_we;
            ram_addr  = host_addr;
            ram_wdata = host_wdata;
            win_we    = host_we;
        end
    end

    // -------------------------------------------------------------------------
    // Read return. The RAM presents data the cycle after a read access, so
    // the owner recorded at the grant edge selects which port sees it. The
    // returned value passes straight through in the valid cycle and is then
    // captured so each port's rdata holds its last value afterwards. During
    // reset both returns are suppressed so a read granted just before reset
    // never surfaces.
    // -------------------------------------------------------------------------
    assign cpu_ret  = rd_pending_q & (rd_owner_q == WIN_CPU)  & ~reset;
    assign host_ret = rd_pending_q & (rd_owner_q == WIN_HOST) & ~reset;

    assign cpu_rvalid  = cpu_ret;
    assign host_rvalid = host_ret;

    always_comb begin
        cpu_rdata  = cpu_rdata_q;
        host_rdata = host_rdata_q;
        if (reset) begin
            cpu_rdata  = '0;
            host_rdata = '0;
        end else begin
            if (cpu_ret) begin
                cpu_rdata = ram_rdata;
            end
            if (host_ret) begin
                host_rdata = ram_rdata;
            end
        end
    end

    assign conflict_cnt = reset ? 8'h00 : conflict_cnt_q;

    // -------------------------------------------------------------------------
    // Next-state logic. Arbitration state only moves on a grant; with no
    // grant the winner history and burst count are left alone.
    // -------------------------------------------------------------------------
    always_comb begin
        last_winner_d  = last_winner_q;
        burst_cnt_d    = burst_cnt_q;
        rd_pending_d   = 1'b0;
        rd_owner_d     = rd_owner_q;
        cpu_rdata_d    = cpu_rdata_q;
        host_rdata_d   = host_rdata_q;
        conflict_cnt_d = conflict_cnt_q;

        if (cpu_win) begin
            last_winner_d = WIN_CPU;
            burst_cnt_d   = '0;
        end else if (host_win) begin
            last_winner_d = WIN_HOST;
            if (host_lock) begin
                burst_cnt_d = (burst_cnt_q == BURST_MAX)
                            ? BURST_MAX
                            : burst_cnt_q + BURST_W'(1);
            end else begin
                burst_cnt_d = '0;
            end
        end

        // Any granted read arms a return for the following cycle.
        if ((cpu_win | host_win) && !win_we) begin
            rd_pending_d = 1'b1;
            rd_owner_d   = cpu_win ? WIN_CPU : WIN_HOST;
        end

        if (cpu_ret) begin
            cpu_rdata_d = ram_rdata;
        end
        if (host_ret) begin
            host_rdata_d = ram_rdata;
        end

        if (both_req && (conflict_cnt_q != CONFLICT_MAX)) begin
            conflict_cnt_d = conflict_cnt_q + 8'd1;
        end
    end

    // -------------------------------------------------------------------------
    // State registers. Reset leaves last_winner at HOST so the CPU takes the
    // first contended cycle, and drops any read still in flight.
    // -------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            last_winner_q  <= WIN_HOST;
            burst_cnt_q    <= '0;
            rd_pending_q   <= 1'b0;
            rd_owner_q     <= WIN_CPU;
            cpu_rdata_q    <= '0;
            host_rdata_q   <= '0;
            conflict_cnt_q <= '0;
        end else begin
            last_winner_q  <= last_winner_d;
            burst_cnt_q    <= burst_cnt_d;
            rd_pending_q   <= rd_pending_d;
            rd_owner_q     <= rd_owner_d;
            cpu_rdata_q    <= cpu_rdata_d;
            host_rdata_q   <= host_rdata_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

endmodule

// File: tb/tb_nibbler_ram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_nibbler_ram_arbiter
//
// Directed bench for nibbler_ram_arbiter with a behavioural 4096x4 RAM behind
// it. Stimulus pushes hand-computed read data into per-port queues whenever a
// read is granted; an independent monitor pops and compares whenever either
// port raises rvalid.
// -----------------------------------------------------------------------------
module tb_nibbler_ram_arbiter;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 4;

    logic              clock = 1'b0;
    logic              reset;
    logic              cpu_req, cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt, cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;
    logic              host_req, host_we, host_lock;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_gnt, host_rvalid;
    logic [DATA_W-1:0] host_rdata;
    logic              ram_cs, ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic [7:0]        conflict_cnt;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] cpu_exp_q[$];
    logic [DATA_W-1:0] host_exp_q[$];

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    nibbler_ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_gnt     (cpu_gnt),
        .cpu_rvalid  (cpu_rvalid),
        .cpu_rdata   (cpu_rdata),
        .host_req    (host_req),
        .host_we     (host_we),
        .host_lock   (host_lock),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_gnt    (host_gnt),
        .host_rvalid (host_rvalid),
        .host_rdata  (host_rdata),
        .ram_cs      (ram_cs),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata),
        .conflict_cnt(conflict_cnt)
    );

    always #5 clock = ~clock;

    // Synchronous-read RAM macro model: data appears the cycle after a read.
    initial ram_rdata = '0;
    always @(posedge clock) begin
        if (ram_cs) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever a port presents read data.
    always @(negedge clock) begin
        if (cpu_rvalid) begin
            if (cpu_exp_q.size() == 0) begin
                check_output("cpu_rvalid_unexpected", 32'(cpu_rvalid), 32'd0);
            end else begin
                check_output("cpu_rdata", 32'(cpu_rdata), 32'(cpu_exp_q.pop_front()));
            end
        end
        if (host_rvalid) begin
            if (host_exp_q.size() == 0) begin
                check_output("host_rvalid_unexpected", 32'(host_rvalid), 32'd0);
            end else begin
                check_output("host_rdata", 32'(host_rdata), 32'(host_exp_q.pop_front()));
            end
        end
    end

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_stimulus(input logic c_req, input logic c_we,
                                  input logic [ADDR_W-1:0] c_addr,
                                  input logic [DATA_W-1:0] c_wdata,
                                  input logic h_req, input logic h_we,
                                  input logic h_lock,
                                  input logic [ADDR_W-1:0] h_addr,
                                  input logic [DATA_W-1:0] h_wdata);
        cpu_req = c_req; cpu_we = c_we; cpu_addr = c_addr; cpu_wdata = c_wdata;
        host_req = h_req; host_we = h_we; host_lock = h_lock;
        host_addr = h_addr; host_wdata = h_wdata;
    endtask

    // Waits for the negedge of the current cycle, checks the grant pattern and
    // RAM drive, and queues the expected return for a granted read.
    task automatic grant_cycle(input string name, input logic exp_cpu,
                               input logic exp_host,
                               input logic [DATA_W-1:0] cpu_data,
                               input logic [DATA_W-1:0] host_data,
                               input bit keep);
        @(negedge clock);
        check_output({name, "_cpu_gnt"},  32'(cpu_gnt),  32'(exp_cpu));
        check_output({name, "_host_gnt"}, 32'(host_gnt), 32'(exp_host));
        check_output({name, "_ram_cs"},   32'(ram_cs),   32'(exp_cpu | exp_host));
        if (exp_cpu) begin
            check_output({name, "_ram_addr"}, 32'(ram_addr), 32'(cpu_addr));
            check_output({name, "_ram_we"},   32'(ram_we),   32'(cpu_we));
            if (!cpu_we && keep) cpu_exp_q.push_back(cpu_data);
        end else if (exp_host) begin
            check_output({name, "_ram_addr"}, 32'(ram_addr), 32'(host_addr));
            check_output({name, "_ram_we"},   32'(ram_we),   32'(host_we));
            if (!host_we && keep) host_exp_q.push_back(host_data);
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) next_cycle();
        reset = 1'b0;
    endtask

    initial begin
        int max_wait;
        int cur_wait;
        logic eh;
        logic ec;

        reset = 1'b1;
        apply_stimulus(1'b1, 1'b0, 12'h000, 4'h0, 1'b1, 1'b0, 1'b0, 12'h000, 4'h0);
        next_cycle();

        // Reset state with both requests high: grants must be forced low.
        @(negedge clock);
        check_output("rst_cpu_gnt",  32'(cpu_gnt),      32'd0);
        check_output("rst_host_gnt", 32'(host_gnt),     32'd0);
        check_output("rst_ram_cs",   32'(ram_cs),       32'd0);
        check_output("rst_conflict", 32'(conflict_cnt), 32'd0);
        check_output("rst_cpu_rdata",  32'(cpu_rdata),  32'd0);
        check_output("rst_host_rdata", 32'(host_rdata), 32'd0);
        next_cycle();
        reset = 1'b0;

        // CPU write 0x005 <- 0xA, then read it back.
        $display("[TB] cpu write/read");
        apply_stimulus(1'b1, 1'b1, 12'h005, 4'hA, 1'b0, 1'b0, 1'b0, 12'h000, 4'h0);
        grant_cycle("cpu_wr", 1'b1, 1'b0, 4'h0, 4'h0, 1'b1);
        next_cycle();
        apply_stimulus(1'b1, 1'b0, 12'h005, 4'h0, 1'b0, 1'b0, 1'b0, 12'h000, 4'h0);
        grant_cycle("cpu_rd", 1'b1, 1'b0, 4'hA, 4'h0, 1'b1);
        next_cycle();
        apply_stimulus(1'b0, 1'b0, 12'h000, 4'h0, 1'b0, 1'b0, 1'b0, 12'h000, 4'h0);
        @(negedge clock);
        check_output("cpu_rvalid_after_read", 32'(cpu_rvalid), 32'd1);
        check_output("host_rvalid_idle",      32'(host_rvalid), 32'd0);
        check_output("idle_ram_addr",  32'(ram_addr),  32'd0);
        check_output("idle_ram_wdata", 32'(ram_wdata), 32'd0);
        next_cycle();

        // Unlocked contention: CPU, HOST, CPU, HOST after reset.
        $display("[TB] round robin");
        do_reset(1);
        apply_stimulus(1'b1, 1'b1, 12'h010, 4'h1, 1'b1, 1'b1, 1'b0, 12'h020, 4'h2);
        for (int k = 0; k < 4; k++) begin
            grant_cycle("rr", (k % 2) == 0, (k % 2) == 1, 4'h0, 4'h0, 1'b1);
            check_output("rr_conflict", 32'(conflict_cnt), 32'(k));
            next_cycle();
        end
        apply_stimulus(1'b0, 1'b0, 12'h000, 4'h0, 1'b0, 1'b0, 1'b0, 12'h000, 4'h0);
        @(negedge clock);
        check_output("rr_conflict_final", 32'(conflict_cnt), 32'd4);
        next_cycle();

        // Locked host burst: CPU granted first, host then holds for 8 grants,
        // CPU granted on the 9th contended cycle, host finishes its 12 reads.
        $display("[TB] locked burst");
        max_wait = 0;
        cur_wait = 0;
        for (int k = 0; k < 14; k++) begin
            if (k == 0)
                apply_stimulus(1'b1, 1'b0, 12'h010, 4'h0, 1'b0, 1'b0, 1'b1, 12'h010, 4'h0);
            else if (k <= 9)
                apply_stimulus(1'b1, 1'b0, 12'h020, 4'h0, 1'b1, 1'b0, 1'b1, 12'h010, 4'h0);
            else
                apply_stimulus(1'b0, 1'b0, 12'h000, 4'h0, 1'b1, 1'b0, 1'b1, 12'h010, 4'h0);
            ec = (k == 0) || (k == 9);
            eh = (k >= 1) && (k != 9);
            grant_cycle("burst", ec, eh, (k == 0) ? 4'h1 : 4'h2, 4'h1, 1'b1);
            if (cpu_req && !cpu_gnt) cur_wait++;
            else cur_wait = 0;
            if (cur_wait > max_wait) max_wait = cur_wait;
            next_cycle();
        end
        apply_stimulus(1'b0, 1'b0, 12'h000, 4'h0, 1'b0, 1'b0, 1'b0, 12'h000, 4'h0);
        check_output("cpu_wait_bound", 32'(max_wait <= 8), 32'd1);
        next_cycle();

        // Same-cycle host write / CPU read with CPU as last winner.
        $display("[TB] write then read same address");
        apply_stimulus(1'b1, 1'b1, 12'h0FF, 4'h0, 1'b0, 1'b0, 1'b0, 12'h000, 4'h0);
        grant_cycle("pre_wr", 1'b1, 1'b0, 4'h0, 4'h0, 1'b1);
        next_cycle();
        apply_stimulus(1'b1, 1'b0, 12'h0FF, 4'h0, 1'b1, 1'b1, 1'b0, 12'h0FF, 4'h3);
        grant_cycle("wr_host_first", 1'b0, 1'b1, 4'h0, 4'h0, 1'b1);
        next_cycle();
        apply_stimulus(1'b1, 1'b0, 12'h0FF, 4'h0, 1'b0, 1'b0, 1'b0, 12'h000, 4'h0);
        grant_cycle("rd_cpu_next", 1'b1, 1'b0, 4'h3, 4'h0, 1'b1);
        next_cycle();

        // Host read immediately followed by reset: return must be dropped.
        $display("[TB] reset drops pending read");
        apply_stimulus(1'b0, 1'b0, 12'h000, 4'h0, 1'b1, 1'b0, 1'b0, 12'h0FF, 4'h0);
        grant_cycle("rd_before_rst", 1'b0, 1'b1, 4'h0, 4'h0, 1'b0);
        next_cycle();
        reset = 1'b1;
        apply_stimulus(1'b1, 1'b1, 12'h030, 4'h5, 1'b1, 1'b1, 1'b0, 12'h031, 4'h6);
        @(negedge clock);
        check_output("mid_rst_host_rvalid", 32'(host_rvalid), 32'd0);
        check_output("mid_rst_host_gnt",    32'(host_gnt),    32'd0);
        check_output("mid_rst_ram_we",      32'(ram_we),      32'd0);
        check_output("mid_rst_host_rdata",  32'(host_rdata),  32'd0);
        next_cycle();
        reset = 1'b0;
        grant_cycle("first_after_rst", 1'b1, 1'b0, 4'h0, 4'h0, 1'b1);
        @(posedge clock);
        #1;
        // Still contending; next cycle goes to the host by round-robin.
        @(negedge clock);
        check_output("after_rst_rvalid", 32'(host_rvalid), 32'd0);
        next_cycle();

        // Conflict counter saturation.
        $display("[TB] conflict saturation");
        do_reset(1);
        apply_stimulus(1'b1, 1'b1, 12'h040, 4'h7, 1'b1, 1'b1, 1'b0, 12'h041, 4'h8);
        for (int k = 0; k < 300; k++) begin
            @(negedge clock);
            if (k == 254) check_output("conflict_254", 32'(conflict_cnt), 32'd254);
            if (k == 255) check_output("conflict_255", 32'(conflict_cnt), 32'd255);
            if (k == 299) check_output("conflict_sat", 32'(conflict_cnt), 32'd255);
            next_cycle();
        end
        apply_stimulus(1'b0, 1'b0, 12'h000, 4'h0, 1'b0, 1'b0, 1'b0, 12'h000, 4'h0);
        next_cycle();
        next_cycle();

        check_output("cpu_queue_drained",  32'(cpu_exp_q.size()),  32'd0);
        check_output("host_queue_drained", 32'(host_exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
